// File: rtl/mux_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and helpers for the 4:1 bit-mux scan sequencer.
//   CH_N     number of mux inputs scanned
//   state_t  sequencer FSM states (IDLE, SETTLE, HOLD)
//   ch2sel   channel index -> mux select code (the mux decodes s bit-reversed)
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int CH_N = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        HOLD   = 2'b10
    } state_t;

    // The mux wires its s inputs bit-reversed, so channel k needs sel = {k[0],k[1]}.
    function automatic logic [1:0] ch2sel(input logic [1:0] ch);
        return {ch[0], ch[1]};
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer_if
// Valid/ready sample port of the scan sequencer.
//   smp_valid  sample available            (master -> slave)
//   smp_ready  downstream accepts sample   (slave  -> master)
//   smp_ch     channel index of the sample (master -> slave)
//   smp_bit    sampled mux output value    (master -> slave)
// -----------------------------------------------------------------------------
interface mux_scan_sequencer_if;

    logic       smp_valid;
    logic       smp_ready;
    logic [1:0] smp_ch;
    logic       smp_bit;

    modport master (
        output smp_valid,
        output smp_ch,
        output smp_bit,
        input  smp_ready
    );

    modport slave (
        input  smp_valid,
        input  smp_ch,
        input  smp_bit,
        output smp_ready
    );

endinterface

// File: rtl/mux_scan_rr_pick.sv
// -----------------------------------------------------------------------------
// mux_scan_rr_pick
// Combinational round-robin picker: next set bit of mask strictly after cur,
// wrapping 3 -> 0. If cur is the only set bit, cur itself is returned.
// Calling with cur = 3 yields the lowest set bit.
//   mask  in  4  channel enable mask
//   cur   in  2  current channel
//   nxt   out 2  next enabled channel (cur when mask is empty)
//   none  out 1  mask has no bits set
// -----------------------------------------------------------------------------
module mux_scan_rr_pick
    import mux_scan_pkg::*;
(
    input  logic [CH_N-1:0] mask,
    input  logic [1:0]      cur,
    output logic [1:0]      nxt,
    output logic            none
);

    logic [1:0] nxt_s;
    logic [1:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        nxt_s = cur;
        idx_s = cur;
        for (int i = CH_N; i >= 1; i--) begin
            idx_s = cur + i[1:0];
            nxt_s = mask[idx_s] ? idx_s : nxt_s;
        end
    end

    assign nxt  = nxt_s;
    assign none = (mask == {CH_N{1'b0}});

endmodule

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Scans enabled channels of a 4:1 bit mux round-robin. Each channel is held
// for DWELL cycles to settle, then the mux output is sampled and presented,
// tagged with its channel, on a valid/ready port.
//
// Optional feature macro: MUX_SCAN_OVERRUN_EN
//   undefined: the sampler waits in HOLD until the sample is accepted.
//   defined  : HOLD is skipped; an unaccepted sample is overwritten by the
//              next capture and the sticky overrun flag is raised.
//
// Parameters
//   DWELL    settle cycles per channel (1..255)
//   DWELL_W  dwell counter width, derived
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start    1-cycle pulse, begins scanning from IDLE
//   stop     level, scanning ends at the next sample boundary
//   ch_en    channel enable mask
//   sel      mux select code (bit-reversed channel index)
//   mux_o    mux output, sampled at the end of the dwell
//   busy     high whenever not IDLE
//   smp      sample port (master side)
//   overrun  sticky overrun flag (MUX_SCAN_OVERRUN_EN only)
// -----------------------------------------------------------------------------
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int DWELL_W = $clog2(DWELL + 1)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [CH_N-1:0] ch_en,
    output logic [1:0]      sel,
    input  logic            mux_o,
    output logic            busy,
    mux_scan_sequencer_if.master smp
`ifdef MUX_SCAN_OVERRUN_EN
    ,
    output logic            overrun
`endif
);

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

    state_t             state_r;
    logic [1:0]         cur_r;
    logic [1:0]         sel_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               valid_r;
    logic [1:0]         ch_r;
    logic               bit_r;
    logic               busy_r;
    logic               stop_pend_r;
`ifdef MUX_SCAN_OVERRUN_EN
    logic               overrun_r;
`endif

    logic [1:0]         pick_cur_s;
    logic [1:0]         pick_nxt_s;
    logic               pick_none_s;
    logic               hs_s;
    logic               end_s;

    // From IDLE search from channel 3 so the lowest enabled channel is found.
    assign pick_cur_s = (state_r == IDLE) ? 2'd3 : cur_r;

    mux_scan_rr_pick u_pick (
        .mask (ch_en),
        .cur  (pick_cur_s),
        .nxt  (pick_nxt_s),
        .none (pick_none_s)
    );

    assign hs_s = valid_r & smp.smp_ready;
    // A stop seen at any point during the dwell (latched) or now ends the scan.
    assign end_s = stop | stop_pend_r | pick_none_s;

    // Sequencer FSM with dwell counter, sample register and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cur_r       <= 2'd0;
            sel_r       <= 2'b00;
            cnt_r       <= {DWELL_W{1'b0}};
            valid_r     <= 1'b0;
            ch_r        <= 2'd0;
            bit_r       <= 1'b0;
            busy_r      <= 1'b0;
            stop_pend_r <= 1'b0;
`ifdef MUX_SCAN_OVERRUN_EN
            overrun_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    stop_pend_r <= 1'b0;
                    if (hs_s) begin
                        valid_r <= 1'b0;
                    end
                    if (start && !stop && !pick_none_s) begin
                        cur_r   <= pick_nxt_s;
                        sel_r   <= ch2sel(pick_nxt_s);
                        cnt_r   <= {DWELL_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= SETTLE;
`ifdef MUX_SCAN_OVERRUN_EN
                        overrun_r <= 1'b0;
`endif
                    end
                end

                SETTLE: begin
                    if (stop) begin
                        stop_pend_r <= 1'b1;
                    end
                    if (cnt_r == CNT_LAST) begin
                        bit_r   <= mux_o;
                        ch_r    <= cur_r;
                        valid_r <= 1'b1;
`ifdef MUX_SCAN_OVERRUN_EN
                        // Old sample still pending and not taken this cycle: it is lost.
                        if (valid_r && !smp.smp_ready) begin
                            overrun_r <= 1'b1;
                        end
                        if (end_s) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            stop_pend_r <= 1'b0;
                        end else begin
                            cur_r <= pick_nxt_s;
                            sel_r <= ch2sel(pick_nxt_s);
                            cnt_r <= {DWELL_W{1'b0}};
                        end
`else
                        cnt_r   <= {DWELL_W{1'b0}};
                        state_r <= HOLD;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (hs_s) begin
                            valid_r <= 1'b0;
                        end
                    end
                end

                HOLD: begin
                    if (stop) begin
                        stop_pend_r <= 1'b1;
                    end
                    if (hs_s) begin
                        valid_r <= 1'b0;
                        if (end_s) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            stop_pend_r <= 1'b0;
                        end else begin
                            cur_r   <= pick_nxt_s;
                            sel_r   <= ch2sel(pick_nxt_s);
                            cnt_r   <= {DWELL_W{1'b0}};
                            state_r <= SETTLE;
                        end
                    end
                end

                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel           = sel_r;
    assign busy          = busy_r;
    assign smp.smp_valid = valid_r;
    assign smp.smp_ch    = ch_r;
    assign smp.smp_bit   = bit_r;
`ifdef MUX_SCAN_OVERRUN_EN
    assign overrun       = overrun_r;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Self-checking bench for mux_scan_sequencer. A behavioural model tracks the
// expected outputs each cycle; directed scenarios add literal expectations.
// Honours MUX_SCAN_OVERRUN_EN (runs the overrun scenario with DWELL=2).
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_OVERRUN_EN
    localparam int DW = 2;
`else
    localparam int DW = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] ch_en = 4'b0000;
    logic [3:0] mux_in = 4'b0000;
    logic       mux_o;
    logic [1:0] sel;
    logic       busy;
`ifdef MUX_SCAN_OVERRUN_EN
    logic       overrun;
`endif

    mux_scan_sequencer_if smp_bus ();

    // Mux with bit-reversed select decoding.
    assign mux_o = mux_in[{sel[0], sel[1]}];

    mux_scan_sequencer #(.DWELL(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .ch_en   (ch_en),
        .sel     (sel),
        .mux_o   (mux_o),
        .busy    (busy),
        .smp     (smp_bus.master)
`ifdef MUX_SCAN_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model state
    bit m_busy, m_hold, m_stop, m_valid, m_bit, m_ovr;
    int m_cur, m_left, m_ch;
    bit m_hs;

    int q_ch[$];
    int q_bit[$];
    int q_sel[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int first_after(input logic [3:0] mask, input int cur);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (cur + k) % 4;
            if (mask[idx]) return idx;
        end
        return cur;
    endfunction

    task automatic m_advance();
        if (m_stop || ch_en == 4'b0000) begin
            m_busy = 1'b0;
        end else begin
            m_cur  = first_after(ch_en, m_cur);
            m_left = DW;
        end
    endtask

    // Behavioural model: countdown of settle cycles, one pending sample slot.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_hold = 0; m_stop = 0; m_valid = 0; m_bit = 0; m_ovr = 0;
            m_cur = 0; m_left = 0; m_ch = 0;
        end else begin
            m_hs = m_valid && (smp_bus.smp_ready === 1'b1);
            if (!m_busy) begin
                if (m_hs) m_valid = 0;
                if (start && !stop && ch_en != 4'b0000) begin
                    m_busy = 1; m_cur = first_after(ch_en, 3); m_left = DW;
                    m_stop = 0; m_ovr = 0;
                end
            end else begin
                if (stop) m_stop = 1;
                if (!m_hold) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
`ifdef MUX_SCAN_OVERRUN_EN
                        if (m_valid && !m_hs) m_ovr = 1;
                        m_valid = 1; m_ch = m_cur; m_bit = mux_in[m_cur];
                        m_advance();
`else
                        m_valid = 1; m_ch = m_cur; m_bit = mux_in[m_cur];
                        m_hold = 1;
`endif
                    end else if (m_hs) begin
                        m_valid = 0;
                    end
                end else if (m_hs) begin
                    m_valid = 0; m_hold = 0;
                    m_advance();
                end
            end
        end
    end

    // Log every accepted sample with the select code in force.
    always @(posedge clk) begin
        if (!rst && smp_bus.smp_valid === 1'b1 && smp_bus.smp_ready === 1'b1) begin
            q_ch.push_back(int'(smp_bus.smp_ch));
            q_bit.push_back(int'(smp_bus.smp_bit));
            q_sel.push_back(int'(sel));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, m_busy);
            check("sel", sel, {m_cur[0], m_cur[1]});
            check("smp_valid", smp_bus.smp_valid, m_valid);
            check("smp_ch", smp_bus.smp_ch, m_ch);
            check("smp_bit", smp_bus.smp_bit, m_bit);
`ifdef MUX_SCAN_OVERRUN_EN
            check("overrun", overrun, m_ovr);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(nm, busy, 1'b0);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (smp_bus.smp_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(nm, smp_bus.smp_valid, 1'b1);
    endtask

    task automatic clear_log();
        q_ch.delete();
        q_bit.delete();
        q_sel.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int exp_ch[4];
        int exp_bit[4];
        int exp_sel[4];
        exp_ch  = '{0, 1, 3, 0};
        exp_bit = '{0, 1, 0, 0};
        exp_sel = '{0, 2, 3, 0};

        smp_bus.smp_ready = 1'b0;
        tick(2);
        chk_on = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_sel", sel, 2'b00);
        check("rst_valid", smp_bus.smp_valid, 1'b0);
        check("rst_ch", smp_bus.smp_ch, 2'd0);
        check("rst_bit", smp_bus.smp_bit, 1'b0);
        rst = 1'b0;
        tick(1);

        // Reset in the middle of a dwell
        ch_en = 4'b1011; mux_in = 4'b0110; smp_bus.smp_ready = 1'b1;
        pulse_start();
        tick(1);
        check("mid_settle_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_busy", busy, 1'b0);
        tick(1);
        check("rst_mid_valid", smp_bus.smp_valid, 1'b0);
        check("rst_mid_sel", sel, 2'b00);
        rst = 1'b0;
        tick(1);

`ifndef MUX_SCAN_OVERRUN_EN
        // Scan order and first-sample latency
        clear_log();
        ch_en = 4'b1011; mux_in = 4'b0110; smp_bus.smp_ready = 1'b1;
        start = 1'b1;
        n = 0;
        while (smp_bus.smp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check("first_latency", n, 5);
        n = 0;
        while (q_ch.size() < 4 && n < 60) begin
            tick(1);
            n++;
        end
        stop = 1'b1;
        wait_idle("order_idle", 40);
        stop = 1'b0;
        check("order_count_ok", q_ch.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("order_ch", (q_ch.size() > i) ? q_ch[i] : 99, exp_ch[i]);
            check("order_bit", (q_bit.size() > i) ? q_bit[i] : 99, exp_bit[i]);
            check("order_sel", (q_sel.size() > i) ? q_sel[i] : 99, exp_sel[i]);
        end

        // Backpressure: sample and select frozen while not ready
        ch_en = 4'b1011; mux_in = 4'b0001; smp_bus.smp_ready = 1'b0;
        pulse_start();
        wait_valid("bp_valid", 20);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", smp_bus.smp_valid, 1'b1);
            check("bp_hold_ch", smp_bus.smp_ch, 2'd0);
            check("bp_hold_bit", smp_bus.smp_bit, 1'b1);
            check("bp_hold_sel", sel, 2'b00);
            tick(1);
        end
        smp_bus.smp_ready = 1'b1;
        tick(1);
        check("bp_release_valid", smp_bus.smp_valid, 1'b0);
        check("bp_release_sel", sel, 2'b10);
        stop = 1'b1;
        wait_idle("bp_idle", 40);
        stop = 1'b0;

        // Single channel, then mask cleared mid-dwell
        clear_log();
        ch_en = 4'b0100; mux_in = 4'b0100; smp_bus.smp_ready = 1'b1;
        pulse_start();
        n = 0;
        while (q_ch.size() < 3 && n < 40) begin
            tick(1);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check("single_ch", (q_ch.size() > i) ? q_ch[i] : 99, 2);
            check("single_sel", (q_sel.size() > i) ? q_sel[i] : 99, 1);
            check("single_bit", (q_bit.size() > i) ? q_bit[i] : 99, 1);
        end
        wait_valid("single_valid", 20);
        tick(2);
        ch_en = 4'b0000;
        n0 = q_ch.size();
        wait_idle("mask_clear_idle", 40);
        check("mask_clear_count", q_ch.size(), n0 + 1);

        // Stop one cycle into the dwell
        clear_log();
        ch_en = 4'b1011; mux_in = 4'b0110; smp_bus.smp_ready = 1'b1;
        pulse_start();
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("stop_idle", 40);
        check("stop_count", q_ch.size(), 1);

        // Start with empty mask, then start together with stop
        ch_en = 4'b0000;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("empty_busy", busy, 1'b0);
            check("empty_valid", smp_bus.smp_valid, 1'b0);
            tick(1);
        end
        ch_en = 4'b1011;
        stop = 1'b1;
        pulse_start();
        stop = 1'b0;
        check("start_stop_busy", busy, 1'b0);
        tick(3);
        check("start_stop_busy_later", busy, 1'b0);
`else
        // Overrun: unaccepted sample overwritten, sticky flag
        ch_en = 4'b0001; mux_in = 4'b0001; smp_bus.smp_ready = 1'b0;
        pulse_start();
        wait_valid("ovr_first_valid", 10);
        check("ovr_first_bit", smp_bus.smp_bit, 1'b1);
        check("ovr_first_flag", overrun, 1'b0);
        mux_in = 4'b0000;
        tick(2);
        check("ovr_second_flag", overrun, 1'b1);
        check("ovr_second_valid", smp_bus.smp_valid, 1'b1);
        check("ovr_second_bit", smp_bus.smp_bit, 1'b0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("ovr_idle", 20);
        check("ovr_sticky", overrun, 1'b1);
        smp_bus.smp_ready = 1'b1;
        tick(2);
        check("ovr_drain_valid", smp_bus.smp_valid, 1'b0);
        check("ovr_drain_sticky", overrun, 1'b1);
        smp_bus.smp_ready = 1'b0;
        pulse_start();
        check("ovr_start_clear", overrun, 1'b0);
        tick(6);
        check("ovr_again", overrun, 1'b1);
        rst = 1'b1;
        tick(1);
        check("ovr_rst_clear", overrun, 1'b0);
        rst = 1'b0;
        tick(1);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
